// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    WR     = 2'd2,
    IOWAIT = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IO_MASK = 32'h0003_0000;

  function automatic logic is_io(input logic [31:0] addr);
    return ((addr & IO_MASK) == IO_BASE);
  endfunction

  // Size code 3 is illegal and handled as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    get_lane = w[7:0];
      2'd1:    get_lane = w[15:8];
      2'd2:    get_lane = w[23:16];
      default: get_lane = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto an 8-bit synchronous-read bus,
// serialising each access into byte cycles and assembling read words.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              ls_req_in,
  input  logic              ls_we_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [1:0]        ls_size_in,
  input  logic [31:0]       ls_wdata_in,
  output logic              ls_done_out,
  output logic [31:0]       ls_rdata_out,
  input  logic [7:0]        mem_din_in,
  output logic [7:0]        mem_dout_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out,
  input  logic              io_buffer_full_in
);

  state_e            state_r;
  logic [2:0]        cnt_r;
  logic [2:0]        nbytes_r;
  logic              is_ls_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       buf_r;
  logic [7:0]        hold_r;
  logic              held_r;

  logic [2:0]        next_s;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [7:0]        byte_s;
  logic [31:0]       rd_word_s;
  logic              take_ls_s;
  logic              take_if_s;

  // Next-byte addressing, arbitration and read-lane merge.
  // A byte that arrived just as rdy dropped is kept in hold_r so it is not lost.
  always_comb begin
    next_s     = cnt_r + 3'd1;
    nxt_addr_s = addr_r + ADDR_W'(next_s);
    cur_addr_s = addr_r + ADDR_W'(cnt_r);
    byte_s     = held_r ? hold_r : mem_din_in;
    take_ls_s  = ls_req_in && !ls_done_out;
    take_if_s  = if_req_in && !if_done_out && !take_ls_s;
    rd_word_s  = buf_r;
    case (cnt_r)
      3'd1:    rd_word_s[7:0]   = byte_s;
      3'd2:    rd_word_s[15:8]  = byte_s;
      3'd3:    rd_word_s[23:16] = byte_s;
      3'd4:    rd_word_s[31:24] = byte_s;
      default: rd_word_s        = buf_r;
    endcase
  end

  // Controller FSM with registered bus and result outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      nbytes_r     <= 3'd0;
      is_ls_r      <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      buf_r        <= 32'd0;
      hold_r       <= 8'd0;
      held_r       <= 1'b0;
      if_done_out  <= 1'b0;
      if_data_out  <= 32'd0;
      ls_done_out  <= 1'b0;
      ls_rdata_out <= 32'd0;
      mem_dout_out <= 8'd0;
      mem_a_out    <= '0;
      mem_wr_out   <= 1'b0;
    end else if (!rdy_in) begin
      mem_wr_out  <= 1'b0;
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      if (!held_r) begin
        hold_r <= mem_din_in;
        held_r <= 1'b1;
      end
    end else begin
      held_r      <= 1'b0;
      if_done_out <= 1'b0;
      ls_done_out <= 1'b0;
      case (state_r)
        IDLE: begin
          mem_wr_out <= 1'b0;
          cnt_r      <= 3'd0;
          buf_r      <= 32'd0;
          if (take_ls_s) begin
            is_ls_r   <= 1'b1;
            addr_r    <= ls_addr_in;
            nbytes_r  <= size_bytes(ls_size_in);
            wdata_r   <= ls_wdata_in;
            mem_a_out <= ls_addr_in;
            if (!ls_we_in) begin
              state_r <= RD;
            end else if (is_io(ls_addr_in) && io_buffer_full_in) begin
              state_r <= IOWAIT;
            end else begin
              state_r      <= WR;
              mem_dout_out <= ls_wdata_in[7:0];
              mem_wr_out   <= 1'b1;
            end
          end else if (take_if_s) begin
            is_ls_r   <= 1'b0;
            addr_r    <= if_addr_in;
            nbytes_r  <= 3'd4;
            mem_a_out <= if_addr_in;
            state_r   <= RD;
          end
        end
        RD: begin
          if (cnt_r == nbytes_r) begin
            state_r <= IDLE;
            if (is_ls_r) begin
              ls_rdata_out <= rd_word_s;
              ls_done_out  <= 1'b1;
            end else begin
              if_data_out <= rd_word_s;
              if_done_out <= 1'b1;
            end
          end else begin
            cnt_r <= next_s;
            buf_r <= rd_word_s;
            if (next_s < nbytes_r) begin
              mem_a_out <= nxt_addr_s;
            end
          end
        end
        WR: begin
          if (cnt_r == nbytes_r - 3'd1) begin
            mem_wr_out  <= 1'b0;
            ls_done_out <= 1'b1;
            state_r     <= IDLE;
          end else begin
            cnt_r     <= next_s;
            mem_a_out <= nxt_addr_s;
            if (is_io(nxt_addr_s) && io_buffer_full_in) begin
              mem_wr_out <= 1'b0;
              state_r    <= IOWAIT;
            end else begin
              mem_dout_out <= get_lane(wdata_r, next_s[1:0]);
              mem_wr_out   <= 1'b1;
            end
          end
        end
        IOWAIT: begin
          // cnt_r here names the byte still to be written.
          if (!io_buffer_full_in) begin
            state_r      <= WR;
            mem_a_out    <= cur_addr_s;
            mem_dout_out <= get_lane(wdata_r, cnt_r[1:0]);
            mem_wr_out   <= 1'b1;
          end else begin
            mem_wr_out <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          mem_wr_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized checks of mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rdy, if_req, ls_req, ls_we, io_full;
  logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
  logic [1:0]  ls_size;
  logic        if_done, ls_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seed     = 0;

  bit [7:0]    ram     [0:4095];
  bit          written [0:4095];
  bit [7:0]    model   [0:4095];
  bit [7:0]    io_log  [$];
  logic [31:0] wlog_a  [$];
  bit [7:0]    wlog_d  [$];
  int          wlog_t  [$];

  mem_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_done_out(if_done), .if_data_out(if_data),
    .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_addr_in(ls_addr), .ls_size_in(ls_size),
    .ls_wdata_in(ls_wdata), .ls_done_out(ls_done), .ls_rdata_out(ls_rdata),
    .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a), .mem_wr_out(mem_wr),
    .io_buffer_full_in(io_full)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] init_byte(input int s, input int a);
    return 8'((a * 37) ^ (a >> 3) ^ s);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < n; k++) w = w | (32'(model[12'(a + 32'(k))]) << (8 * k));
    return w;
  endfunction

  // Synchronous-read RAM and IO sink seen by the controller.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) begin
        io_log.push_back(mem_dout);
      end else begin
        ram[mem_a[11:0]]     <= mem_dout;
        written[mem_a[11:0]] <= 1'b1;
        wlog_a.push_back(mem_a);
        wlog_d.push_back(mem_dout);
        wlog_t.push_back(cyc);
      end
    end
    mem_din <= written[mem_a[11:0]] ? ram[mem_a[11:0]] : init_byte(seed, int'(mem_a[11:0]));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ls_op(input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output int edges);
    repeat (2) @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = sz; ls_wdata = wd;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); #1; edges++;
      if (ls_done) break;
    end
    check("ls_done_seen", {31'd0, ls_done}, 32'd1);
    rd = ls_rdata;
    ls_req = 1'b0;
    if (we) begin
      for (int k = 0; k < nbytes(sz); k++) model[12'(a + 32'(k))] = wd[8*k +: 8];
    end
  endtask

  task automatic if_op(input logic [31:0] a, output logic [31:0] rd, output int edges);
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = a;
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); #1; edges++;
      if (if_done) break;
    end
    check("if_done_seen", {31'd0, if_done}, 32'd1);
    rd = if_data;
    if_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, lsv, ifv;
    int e, ls_e, if_e, w0, io0, wr_stall, wr_all;
    logic [1:0] sz;
    logic [31:0] a, wd;

    rst_n = 1'b0; rdy = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    io_full = 1'b0; if_addr = 32'd0; ls_addr = 32'd0; ls_size = 2'd0; ls_wdata = 32'd0;
    seed = int'($urandom_range(0, 255));
    for (int i = 0; i < 4096; i++) model[i] = init_byte(seed, i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_ls_done", {31'd0, ls_done}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    rst_n = 1'b1;

    // Program the fetch word, then fetch it
    ls_op(1'b1, 32'h100, 2'd2, 32'h0050_0013, rd, e);
    check("st100_latency", 32'(e), 32'd5);
    w0 = wlog_a.size();
    if_op(32'h100, rd, e);
    check("if100_data", rd, 32'h0050_0013);
    check("if100_latency", 32'(e), 32'd6);
    check("if100_no_wr", 32'(wlog_a.size()), 32'(w0));
    @(posedge clk); #1;
    check("if100_single_pulse", {31'd0, if_done}, 32'd0);

    // Word store with byte-by-byte bus check
    w0 = wlog_a.size();
    ls_op(1'b1, 32'h200, 2'd2, 32'h1234_5678, rd, e);
    check("st200_latency", 32'(e), 32'd5);
    check("st200_nwrites", 32'(wlog_a.size() - w0), 32'd4);
    if (wlog_a.size() - w0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("st200_addr", wlog_a[w0 + k], 32'h200 + 32'(k));
        check("st200_byte", 32'(wlog_d[w0 + k]), 32'(exp_word(32'h200 + 32'(k), 1)));
        check("st200_consecutive", 32'(wlog_t[w0 + k] - wlog_t[w0]), 32'(k));
      end
    end
    ls_op(1'b0, 32'h200, 2'd2, 32'd0, rd, e);
    check("ld200_readback", rd, 32'h1234_5678);

    // Simultaneous requests: load/store side wins
    repeat (2) @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_size = 2'd0;
    if_req = 1'b1; if_addr = 32'h100;
    e = 0; ls_e = 0; if_e = 0; lsv = 32'd0; ifv = 32'd0;
    while (e < 60 && if_e == 0) begin
      @(posedge clk); #1; e++;
      if (ls_done) begin ls_e = e; lsv = ls_rdata; ls_req = 1'b0; end
      if (if_done) begin if_e = e; ifv = if_data; end
    end
    if_req = 1'b0;
    check("arb_ls_latency", 32'(ls_e), 32'd3);
    check("arb_ls_data", lsv, 32'h0000_0078);
    check("arb_if_latency", 32'(if_e), 32'd9);
    check("arb_if_data", ifv, 32'h0050_0013);

    // rdy low for three cycles in the middle of a word read
    w0 = wlog_a.size();
    repeat (2) @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_size = 2'd2;
    e = 0; ls_e = 0; lsv = 32'd0;
    while (e < 60 && ls_e == 0) begin
      @(posedge clk); #1; e++;
      if (e == 3) rdy = 1'b0;
      if (e == 6) rdy = 1'b1;
      if (ls_done) begin ls_e = e; lsv = ls_rdata; end
    end
    ls_req = 1'b0; rdy = 1'b1;
    check("stall_latency", 32'(ls_e), 32'd9);
    check("stall_data", lsv, 32'h1234_5678);
    check("stall_no_wr", 32'(wlog_a.size()), 32'(w0));

    // IO store held off by a full output buffer
    w0 = wlog_a.size(); io0 = io_log.size();
    repeat (2) @(negedge clk);
    io_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wdata = 32'hABCD_EF41;
    e = 0; ls_e = 0; wr_stall = 0; wr_all = 0;
    while (e < 60 && ls_e == 0) begin
      @(posedge clk); #1; e++;
      if (mem_wr) wr_all++;
      if (mem_wr && e <= 4) wr_stall++;
      if (e == 4) io_full = 1'b0;
      if (ls_done) ls_e = e;
    end
    ls_req = 1'b0; io_full = 1'b0;
    check("io_wr_during_full", 32'(wr_stall), 32'd0);
    check("io_wr_cycles", 32'(wr_all), 32'd1);
    check("io_latency", 32'(ls_e), 32'd6);
    check("io_bytes", 32'(io_log.size() - io0), 32'd1);
    if (io_log.size() > io0) check("io_byte_val", 32'(io_log[io0]), 32'h41);
    check("io_no_ram_wr", 32'(wlog_a.size()), 32'(w0));

    // Reset during a fetch
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_if_data", if_data, 32'd0);
    check("midrst_ls_rdata", ls_rdata, 32'd0);
    if_req = 1'b0;
    wr_all = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (if_done || mem_wr) wr_all++;
    end
    check("midrst_quiet", 32'(wr_all), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    if_op(32'h100, rd, e);
    check("postrst_if_data", rd, 32'h0050_0013);
    check("postrst_if_latency", 32'(e), 32'd6);

    // Randomized traffic against the byte-array model
    for (int i = 0; i < 30; i++) begin
      a  = 32'h400 + 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          if_op(a, rd, e);
          check("rnd_if_data", rd, exp_word(a, 4));
          check("rnd_if_latency", 32'(e), 32'd6);
        end
        1: begin
          ls_op(1'b0, a, sz, 32'd0, rd, e);
          check("rnd_ld_data", rd, exp_word(a, nbytes(sz)));
          check("rnd_ld_latency", 32'(e), 32'(nbytes(sz) + 2));
        end
        default: begin
          ls_op(1'b1, a, sz, wd, rd, e);
          check("rnd_st_latency", 32'(e), 32'(nbytes(sz) + 1));
          ls_op(1'b0, a, 2'd2, 32'd0, rd, e);
          check("rnd_st_readback", rd, exp_word(a, 4));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside riscv_top, between the CPU's fetch/load-store requesters and the single-port, 8-bit, synchronous-read RAM/IO bus.
- Arbitrates instruction-fetch (IF) and load/store (LS) requests.
- Serialises each 1/2/4-byte access into consecutive byte cycles, assembles read words and returns a one-cycle done pulse.
- Honours the global rdy_in pause and the IO output-buffer-full backpressure.

Parameters:
- ADDR_W, 32, address width on requester and RAM sides.
- IO_BASE, 32'h0003_0000, first byte of the IO window; any address with bits [17:16]==2'b11 is IO.

Ports:
- clk_in  in  1  system clock, all state on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low freezes the block.
- if_req_in  in  1  fetch request, level; held until if_done_out.
- if_addr_in  in  ADDR_W  fetch word address.
- if_done_out  out  1  one-cycle pulse, if_data_out valid.
- if_data_out  out  32  fetched word, little-endian.
- ls_req_in  in  1  load/store request, level; held until ls_done_out.
- ls_we_in  in  1  1 = store, 0 = load.
- ls_addr_in  in  ADDR_W  byte address.
- ls_size_in  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal (treated as word).
- ls_wdata_in  in  32  store data, low bytes used.
- ls_done_out  out  1  one-cycle pulse.
- ls_rdata_out  out  32  load data, zero-extended (sign extension belongs to the LS unit).
- mem_din_in  in  8  RAM/IO read byte; valid the cycle after its address was presented.
- mem_dout_out  out  8  write byte.
- mem_a_out  out  ADDR_W  byte address.
- mem_wr_out  out  1  write strobe.
- io_buffer_full_in  in  1  IO output FIFO full.

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; all outputs 0; any in-flight access is aborted with no done pulse and no partial data.
- States:
  - IDLE: sample requests.
  - RD: read, byte counter cnt runs 0..N.
  - WR: write, cnt runs 0..N-1.
  - IOWAIT: held IO store.
- Arbitration in IDLE: ls_req_in has priority over if_req_in. A port whose done_out is high in the current cycle is ignored that cycle.
- Byte count N: 1 / 2 / 4 from ls_size_in. IF accesses are always N = 4.
- Read, request accepted at edge E0:
  - Edges E0..E(N-1) drive mem_a_out = addr+0..addr+N-1.
  - Edges E2..E(N+1) capture mem_din_in into byte lanes 0..N-1.
  - At E(N+1): data register updated, done pulse asserted for one cycle, state returns to IDLE.
  - Word read therefore shows done after E5.
- Write, accepted at E0:
  - Edge E(k), k = 0..N-1, drives mem_a_out = addr+k, mem_dout_out = wdata[8k+7:8k], mem_wr_out = 1.
  - At E(N): mem_wr_out = 0, ls_done_out = 1.
- IO store:
  - If the address is IO and io_buffer_full_in=1 at acceptance or before any byte, go to IOWAIT with mem_wr_out=0.
  - Resume WR on the first cycle full is low.
  - Each IO byte write re-checks full.
- mem_wr_out is never 1 in RD or IDLE. mem_a_out is held after completion.
- rdy_in=0:
  - All state, counters and data registers are frozen and mem_wr_out is forced 0.
  - When rdy_in returns, the pending byte is re-issued.
  - Done latency extends by exactly the number of stalled cycles.
- Address arithmetic wraps mod 2^ADDR_W.
- No alignment check. Misaligned half/word accesses are performed bytewise.
- Data outputs keep their last value between transactions.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum (IDLE, RD, WR, IOWAIT).
  - size encodings (SZ_B, SZ_H, SZ_W).
  - IO_BASE.
  - is_io(addr) function.
- No sub-module. Byte-lane assembly is a few lines inside mem_ctrl.

Test Plan:
- IF read 0x100, RAM bytes 13 00 50 00 -> if_data_out 0x00500013; if_done_out is a single pulse after E5; mem_wr_out stays 0.
- LS store word 0x12345678 at 0x200 -> bytes 78,56,34,12 at 0x200..0x203 on four consecutive cycles with wr=1; ls_done_out after E4; RAM readback matches.
- if_req and ls_req (load byte 0x200) rise in the same cycle -> LS first, ls_rdata_out 0x00000078 after E2; IF accepted at the next IDLE and completes 5 cycles later.
- rdy_in low 3 cycles in the middle of a word read -> correct word; done delayed by exactly 3; no wr pulses.
- Store byte 0x41 to 0x30000 with io_buffer_full_in high 4 cycles -> mem_wr_out 0 during the stall, then a single write cycle, ls_done_out on the next cycle.
- rst_n_in low mid word read -> outputs 0 immediately and no done; after release a new IF read of 0x100 completes normally.
